// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: N x W register file with one synchronous write port,
// two combinational read ports and a per-register busy scoreboard.
// A reserve marks a register busy; a write to it clears the busy bit,
// except when a new reserve to the same register lands in the same cycle.
// Indices at or above N are ignored on write/reserve and read back as zero.
// Optional feature: define REGFILE_BYPASS_EN to forward data_in (and the
// post-write busy value) to a read port addressing the register being
// written in the same cycle.
module regfile_2r1w_sb #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  data_in,
    input  logic [AW-1:0] writenum,
    input  logic          write,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsvnum,
    input  logic [AW-1:0] readnum_a,
    input  logic [AW-1:0] readnum_b,
    output logic [W-1:0]  data_out_a,
    output logic [W-1:0]  data_out_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [N-1:0]  busy_vec
);

    logic [W-1:0] regs [N];
    logic [N-1:0] busy;

`ifdef REGFILE_BYPASS_EN
    localparam logic [AW:0] NUM_REGS = (AW+1)'(N);

    logic byp_ok;
    logic byp_busy;

    assign byp_ok   = !reset && write && ({1'b0, writenum} < NUM_REGS);
    assign byp_busy = rsv_en && (rsvnum == writenum);
`endif

    // Storage and scoreboard update; only indices below N can ever match,
    // so out-of-range writes and reserves fall through untouched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                regs[i] <= '0;
                busy[i] <= 1'b0;
            end else begin
                if (write && (writenum == AW'(i))) begin
                    regs[i] <= data_in;
                end
                // A new producer issued in the retire cycle keeps the register busy.
                if (rsv_en && (rsvnum == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (write && (writenum == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports; unmatched (out-of-range) indices read zero.
    always_comb begin
        data_out_a = '0;
        data_out_b = '0;
        busy_a     = 1'b0;
        busy_b     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (readnum_a == AW'(i)) begin
                data_out_a = regs[i];
                busy_a     = busy[i];
            end
            if (readnum_b == AW'(i)) begin
                data_out_b = regs[i];
                busy_b     = busy[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_ok && (writenum == readnum_a)) begin
            data_out_a = data_in;
            busy_a     = byp_busy;
        end
        if (byp_ok && (writenum == readnum_b)) begin
            data_out_b = data_in;
            busy_b     = byp_busy;
        end
`endif
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Testbench for regfile_2r1w_sb: an N=8 instance and an N=6 instance share
// the same stimulus. A table of directed rows, a few hand sequences and a
// randomized run are checked against an array-based reference model.
module tb_regfile_2r1w_sb;

    logic        clk;
    logic        reset;
    logic        write;
    logic        rsv_en;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic [2:0]  rsvnum;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;

    logic [15:0] da8, db8, da6, db6;
    logic        ba8, bb8, ba6, bb6;
    logic [7:0]  bv8;
    logic [5:0]  bv6;

    int tests = 0;
    int fails = 0;

    regfile_2r1w_sb #(.W(16), .N(8), .AW(3)) u_dut8 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .rsv_en(rsv_en), .rsvnum(rsvnum),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(da8), .data_out_b(db8), .busy_a(ba8), .busy_b(bb8),
        .busy_vec(bv8)
    );

    regfile_2r1w_sb #(.W(16), .N(6), .AW(3)) u_dut6 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .rsv_en(rsv_en), .rsvnum(rsvnum),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(da6), .data_out_b(db6), .busy_a(ba6), .busy_b(bb6),
        .busy_vec(bv6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 is the N=8 instance, index 1 the N=6 one.
    logic [15:0] mreg  [2][8];
    logic        mbusy [2][8];

    function automatic int nregs(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    mreg[k][i]  = 16'h0;
                    mbusy[k][i] = 1'b0;
                end
            end else begin
                if (write && (int'(writenum) < nregs(k))) begin
                    mreg[k][writenum]  = data_in;
                    mbusy[k][writenum] = 1'b0;
                end
                if (rsv_en && (int'(rsvnum) < nregs(k)))
                    mbusy[k][rsvnum] = 1'b1;
            end
        end
    endtask

    task automatic model_read(input int k, input logic [2:0] idx,
                              output logic [15:0] d, output logic b);
        d = 16'h0;
        b = 1'b0;
        if (int'(idx) < nregs(k)) begin
            d = mreg[k][idx];
            b = mbusy[k][idx];
            if (BYPASS && !reset && write && (writenum == idx)) begin
                d = data_in;
                b = rsv_en && (rsvnum == writenum);
            end
        end
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] ed;
        logic        eb;
        logic [7:0]  ev;
        for (int k = 0; k < 2; k++) begin
            model_read(k, readnum_a, ed, eb);
            cmp({tag, (k == 0) ? "/n8" : "/n6", " data_a"}, (k == 0) ? da8 : da6, ed);
            cmp({tag, (k == 0) ? "/n8" : "/n6", " busy_a"}, {15'h0, (k == 0) ? ba8 : ba6}, {15'h0, eb});
            model_read(k, readnum_b, ed, eb);
            cmp({tag, (k == 0) ? "/n8" : "/n6", " data_b"}, (k == 0) ? db8 : db6, ed);
            cmp({tag, (k == 0) ? "/n8" : "/n6", " busy_b"}, {15'h0, (k == 0) ? bb8 : bb6}, {15'h0, eb});
            ev = 8'h0;
            for (int i = 0; i < nregs(k); i++) ev[i] = mbusy[k][i];
            cmp({tag, (k == 0) ? "/n8" : "/n6", " busy_vec"},
                {8'h0, (k == 0) ? bv8 : {2'b00, bv6}}, {8'h0, ev});
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        reset  = 1'b0;
        write  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] wn, input logic [15:0] d);
        write = 1'b1; writenum = wn; data_in = d; rsv_en = 1'b0;
        clock_edge();
        write = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        wr;
        logic [2:0]  wn;
        logic [15:0] din;
        logic        rsv;
        logic [2:0]  rn;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic [7:0]  exp_bv;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1, 0, 0, 16'h0000, 0, 0, 0, 7, 16'h0000, 16'h0000, 0, 0, 8'h00};
        vecs[1] = '{0, 1, 3, 16'h1234, 0, 0, 3, 5, 16'h1234, 16'h0000, 0, 0, 8'h00};
        vecs[2] = '{0, 1, 5, 16'hBEEF, 0, 0, 3, 5, 16'h1234, 16'hBEEF, 0, 0, 8'h00};
        vecs[3] = '{0, 0, 0, 16'h0000, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00};
        vecs[4] = '{0, 0, 0, 16'h0000, 1, 2, 2, 5, 16'h0000, 16'hBEEF, 1, 0, 8'h04};
        vecs[5] = '{0, 1, 2, 16'h00AA, 0, 0, 2, 5, 16'h00AA, 16'hBEEF, 0, 0, 8'h00};
        vecs[6] = '{0, 0, 0, 16'h0000, 1, 6, 6, 2, 16'h0000, 16'h00AA, 1, 0, 8'h40};
        vecs[7] = '{0, 1, 6, 16'h7777, 1, 6, 6, 6, 16'h7777, 16'h7777, 1, 1, 8'h40};
        vecs[8] = '{0, 1, 6, 16'h1111, 1, 1, 6, 1, 16'h1111, 16'h0000, 0, 1, 8'h02};
        vecs[9] = '{1, 1, 3, 16'hFFFF, 1, 0, 3, 5, 16'h0000, 16'h0000, 0, 0, 8'h00};

        reset = 1'b1; write = 1'b0; rsv_en = 1'b0;
        data_in = 16'h0; writenum = 3'd0; rsvnum = 3'd0;
        readnum_a = 3'd0; readnum_b = 3'd0;
        clock_edge();
        idle_inputs();
        #1;
        check_all("after_reset");

        // Directed table: apply one row for one edge, then inspect with writes idle.
        for (int r = 0; r < 10; r++) begin
            reset = vecs[r].rst; write = vecs[r].wr; writenum = vecs[r].wn;
            data_in = vecs[r].din; rsv_en = vecs[r].rsv; rsvnum = vecs[r].rn;
            readnum_a = vecs[r].ra; readnum_b = vecs[r].rb;
            #1;
            check_all($sformatf("row%0d_pre", r));
            clock_edge();
            idle_inputs();
            #1;
            cmp($sformatf("row%0d data_a", r), da8, vecs[r].exp_a);
            cmp($sformatf("row%0d data_b", r), db8, vecs[r].exp_b);
            cmp($sformatf("row%0d busy_a", r), {15'h0, ba8}, {15'h0, vecs[r].exp_ba});
            cmp($sformatf("row%0d busy_b", r), {15'h0, bb8}, {15'h0, vecs[r].exp_bb});
            cmp($sformatf("row%0d busy_vec", r), {8'h0, bv8}, {8'h0, vecs[r].exp_bv});
            check_all($sformatf("row%0d_post", r));
        end

        // Reset clears a fully written file.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'hFFFF);
        rsv_en = 1'b1; rsvnum = 3'd4;
        clock_edge();
        reset = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'h9999;
        clock_edge();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i); readnum_b = 3'(7 - i);
            #1;
            cmp($sformatf("rst_all a%0d", i), da8, 16'h0);
            cmp($sformatf("rst_all b%0d", i), db8, 16'h0);
        end
        cmp("rst_all busy_vec", {8'h0, bv8}, 16'h0);

        // Out-of-range on the N=6 instance.
        for (int i = 0; i < 6; i++) do_write(3'(i), 16'(i * 16'h0111 + 1));
        do_write(3'd7, 16'h5555);
        do_write(3'd6, 16'h6666);
        rsv_en = 1'b1; rsvnum = 3'd7;
        clock_edge();
        rsv_en = 1'b0;
        readnum_a = 3'd7; readnum_b = 3'd6;
        #1;
        cmp("oor n6 data_a", da6, 16'h0);
        cmp("oor n6 busy_a", {15'h0, ba6}, 16'h0);
        cmp("oor n6 data_b", db6, 16'h0);
        cmp("oor n8 data_a", da8, 16'h5555);
        cmp("oor n6 busy_vec", {10'h0, bv6}, 16'h0);
        for (int i = 0; i < 6; i++) begin
            readnum_a = 3'(i);
            #1;
            cmp($sformatf("oor n6 keep%0d", i), da6, 16'(i * 16'h0111 + 1));
        end

        // Write-to-read bypass (or its absence) on port B.
        do_write(3'd1, 16'h0101);
        readnum_a = 3'd0; readnum_b = 3'd1;
        write = 1'b1; writenum = 3'd1; data_in = 16'hCAFE;
        #1;
        cmp("bypass same_cycle b", db8, BYPASS ? 16'hCAFE : 16'h0101);
        check_all("bypass_pre");
        clock_edge();
        write = 1'b0;
        #1;
        cmp("bypass next_cycle b", db8, 16'hCAFE);

        // Randomized run against the reference model.
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 31) == 0);
            write     = $urandom_range(0, 1);
            writenum  = 3'($urandom_range(0, 7));
            data_in   = 16'($urandom);
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsvnum    = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom_range(0, 7));
            readnum_a = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom_range(0, 7));
            readnum_b = ($urandom_range(0, 3) == 0) ? readnum_a : 3'($urandom_range(0, 7));
            #1;
            check_all($sformatf("rand%0d", c));
            clock_edge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
